vram_dma_programmer: RTL and testbench

VRAM_DMA_PROGRAMMER -- requirements
Module: vram_dma_programmer

---
 rtl/vram_dma_pkg.sv | 28 ++
 rtl/vram_dma_programmer.sv | 173 +++++++++++++++++
 tb/tb_vram_dma_programmer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dma_pkg.sv
// Shared definitions for the VRAM DMA programmer.
// Holds the sequencer state enum, the DMA engine CSR word indices, the
// control word that launches a transfer, and the IRQ watchdog limit.
package vram_dma_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClrStat = 3'd1,
        StWrRaddr = 3'd2,
        StWrWaddr = 3'd3,
        StWrLen   = 3'd4,
        StWrCtrl  = 3'd5,
        StWaitIrq = 3'd6,
        StAckIrq  = 3'd7
    } vram_dma_state_e;

    localparam logic [2:0] DMA_REG_STATUS = 3'd0;
    localparam logic [2:0] DMA_REG_RADDR  = 3'd1;
    localparam logic [2:0] DMA_REG_WADDR  = 3'd2;
    localparam logic [2:0] DMA_REG_LEN    = 3'd3;
    localparam logic [2:0] DMA_REG_CTRL   = 3'd6;

    // WORD | GO | I_EN | LEEN
    localparam logic [31:0] DMA_CTRL_GO = 32'h0000_009C;

    localparam int unsigned DMA_TIMEOUT_CYCLES = 32'd1 << 20;

endpackage

// File: rtl/vram_dma_programmer.sv
// Programs an Avalon-MM DMA engine to copy one full VRAM frame.
// On start (accepted only when idle) the source byte address is word-aligned
// and latched, then the sequencer clears the DMA status, writes read address,
// write address, length and control (GO), waits for the DMA interrupt and
// finally acknowledges it by clearing status again.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, src_addr   transfer request and CPU source byte address
//   busy              high in every non-idle state
//   done              one-cycle pulse on normal completion
//   timeout_err       one-cycle pulse when the IRQ watchdog aborted the wait
//   avm_*             Avalon-MM master towards the DMA CSR slave
//   dma_irq           level interrupt from the DMA engine
//
// Build option: define VRAM_DMA_TIMEOUT_EN to add an IRQ watchdog; without
// it WAIT_IRQ waits forever and timeout_err is tied low.
module vram_dma_programmer
    import vram_dma_pkg::*;
#(
    parameter int unsigned VRAM_LEN = 53568,
    parameter logic [31:0] DST_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        dma_irq
);

    vram_dma_state_e r_state, w_state_nxt;
    logic [31:0]     r_src, w_src_nxt;
    logic            r_done, w_done_nxt;
    logic            w_timeout_nxt;
    logic            w_wd_hit;

`ifdef VRAM_DMA_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(DMA_TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_to_flag, w_to_flag_nxt;
    logic             r_timeout_err;

    // Counter reaches the limit on the last permitted WAIT_IRQ cycle.
    assign w_wd_hit = (r_wait_cnt == CNT_W'(DMA_TIMEOUT_CYCLES - 1));
`else
    assign w_wd_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_src_nxt     = r_src;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
`ifdef VRAM_DMA_TIMEOUT_EN
        w_to_flag_nxt = r_to_flag;
`endif
        avm_write     = 1'b0;
        avm_address   = DMA_REG_STATUS;
        avm_writedata = 32'h0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_src_nxt   = src_addr & 32'hFFFF_FFFC;
                    w_state_nxt = StClrStat;
`ifdef VRAM_DMA_TIMEOUT_EN
                    w_to_flag_nxt = 1'b0;
`endif
                end
            end
            StClrStat: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) w_state_nxt = StWrRaddr;
            end
            StWrRaddr: begin
                avm_write     = 1'b1;
                avm_address   = DMA_REG_RADDR;
                avm_writedata = r_src;
                if (!avm_waitrequest) w_state_nxt = StWrWaddr;
            end
            StWrWaddr: begin
                avm_write     = 1'b1;
                avm_address   = DMA_REG_WADDR;
                avm_writedata = DST_ADDR;
                if (!avm_waitrequest) w_state_nxt = StWrLen;
            end
            StWrLen: begin
                avm_write     = 1'b1;
                avm_address   = DMA_REG_LEN;
                avm_writedata = 32'(VRAM_LEN);
                if (!avm_waitrequest) w_state_nxt = StWrCtrl;
            end
            StWrCtrl: begin
                avm_write     = 1'b1;
                avm_address   = DMA_REG_CTRL;
                avm_writedata = DMA_CTRL_GO;
                if (!avm_waitrequest) w_state_nxt = StWaitIrq;
            end
            StWaitIrq: begin
                if (dma_irq) begin
                    w_state_nxt = StAckIrq;
                end else if (w_wd_hit) begin
                    w_state_nxt = StAckIrq;
`ifdef VRAM_DMA_TIMEOUT_EN
                    w_to_flag_nxt = 1'b1;
`endif
                end
            end
            StAckIrq: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) begin
                    w_state_nxt = StIdle;
`ifdef VRAM_DMA_TIMEOUT_EN
                    w_timeout_nxt = r_to_flag;
                    w_done_nxt    = !r_to_flag;
`else
                    w_done_nxt    = 1'b1;
`endif
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_src   <= 32'h0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef VRAM_DMA_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_to_flag     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_flag     <= w_to_flag_nxt;
            r_timeout_err <= w_timeout_nxt;
            // Clear on entry so every wait starts a fresh watchdog window.
            if (r_state != StWaitIrq && w_state_nxt == StWaitIrq) begin
                r_wait_cnt <= '0;
            end else if (r_state == StWaitIrq) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
    logic w_unused_timeout;
    assign w_unused_timeout = w_timeout_nxt;
`endif

    assign busy = (r_state != StIdle);
    assign done = r_done;

endmodule

// File: tb/tb_vram_dma_programmer.sv
// Self-checking bench for vram_dma_programmer. Expected CSR writes are pushed
// to a scoreboard queue when a start is driven; a negedge monitor collects the
// writes the DUT actually completes, and each scenario task compares them.
module tb_vram_dma_programmer;

    localparam int unsigned VRAM_LEN = 53568;
    localparam logic [31:0] DST_ADDR = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        dma_irq;

    vram_dma_programmer #(
        .VRAM_LEN(VRAM_LEN),
        .DST_ADDR(DST_ADDR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .dma_irq        (dma_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [34:0] exp_q[$];
    logic [34:0] obs_q[$];
    int obs_total = 0;
    int done_cnt  = 0;
    int to_cnt    = 0;
    int checks    = 0;
    int failures  = 0;

    // Monitor: a write completes in a cycle with avm_write=1 and no stall.
    always @(negedge clk) begin
        if (rst_n && avm_write && !avm_waitrequest) begin
            obs_q.push_back({avm_address, avm_writedata});
            obs_total++;
        end
        if (done) done_cnt++;
        if (timeout_err) to_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_seq(input logic [31:0] src);
        exp_q.push_back({3'd0, 32'h0});
        exp_q.push_back({3'd1, src & 32'hFFFF_FFFC});
        exp_q.push_back({3'd2, DST_ADDR});
        exp_q.push_back({3'd3, 32'(VRAM_LEN)});
        exp_q.push_back({3'd6, 32'h0000_009C});
        exp_q.push_back({3'd0, 32'h0});
    endfunction

    // Drives one transfer until done; returns start-to-done latency or -1.
    task automatic run_seq(input logic [31:0] src, input int irq_delay, input int stall,
                           input bit pulse_ignored, input bit already, output int lat);
        int base, cyc, wcnt, stall_left;
        bit irq_on, stalled, pulsed;
        base = obs_total; wcnt = 0; stall_left = 0;
        irq_on = 0; stalled = 0; pulsed = 0; lat = -1;
        if (already) begin
            cyc = 1;
        end else begin
            push_seq(src);
            src_addr = src;
            start    = 1'b1;
            cyc      = 0;
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            start = 1'b0;
            if (stall > 0 && !stalled && avm_write && avm_address == 3'd3) begin
                stalled = 1; stall_left = stall; avm_waitrequest = 1'b1;
            end else if (stall_left > 0) begin
                checks++;
                if (!(avm_write && avm_address == 3'd3 && avm_writedata == 32'(VRAM_LEN))) begin
                    failures++;
                    $display("FAIL stall_hold: got we=%0b addr=%0d data=%0d, required 1/3/%0d",
                             avm_write, avm_address, avm_writedata, VRAM_LEN);
                end
                stall_left--;
                if (stall_left == 0) avm_waitrequest = 1'b0;
            end
            if (obs_total - base >= 5 && !irq_on) begin
                if (pulse_ignored && !pulsed) begin
                    start = 1'b1; src_addr = 32'hFFFF_0000; pulsed = 1;
                end
                if (wcnt == irq_delay) begin
                    dma_irq = 1'b1; irq_on = 1;
                end else begin
                    wcnt++;
                end
            end
            if (done) begin
                lat = cyc;
                break;
            end
        end
        dma_irq = 1'b0;
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL seq_bound: no done within 200 cycles, required done");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; src_addr = 32'h0;
        avm_waitrequest = 1'b0; dma_irq = 1'b0;
        #12;
        checks++;
        if ({busy, done, timeout_err, avm_write} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0000", {busy, done, timeout_err, avm_write});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat, d0;
        d0 = done_cnt;
        run_seq(32'h0001_0003, 2, 0, 0, 0, lat);
        checks++;
        if (lat != 10) begin
            failures++; $display("FAIL basic_latency: got %0d required 10", lat);
        end
        run_seq(32'h1234_5678, 0, 0, 0, 0, lat);
        checks++;
        if (lat != 8) begin
            failures++; $display("FAIL min_latency: got %0d required 8", lat);
        end
        tick(); tick();
        checks++;
        if (done_cnt != d0 + 2 || done !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulses: got %0d required %0d", done_cnt - d0, 2);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL basic_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_waitrequest();
        int lat;
        run_seq(32'h0004_0000, 0, 3, 0, 0, lat);
        checks++;
        if (lat != 11) begin
            failures++; $display("FAIL stall_latency: got %0d required 11", lat);
        end
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL stall_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL stall_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ignore_start();
        int lat, n0;
        run_seq(32'h0008_0010, 3, 0, 1, 0, lat);
        checks++;
        if (lat != 11) begin
            failures++; $display("FAIL ignore_latency: got %0d required 11", lat);
        end
        tick(); tick(); tick();
        n0 = obs_total;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL ignore_no_queue: busy=%b required 0", busy);
        end
        run_seq(32'h0002_0000, 0, 0, 0, 0, lat);
        tick();
        checks++;
        if (obs_total - n0 != 6) begin
            failures++; $display("FAIL ignore_next_count: got %0d required 6", obs_total - n0);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL ignore_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int lat, d0;
        d0 = done_cnt;
        src_addr = 32'h0003_0000; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        checks++;
        if (!(avm_write && avm_address == 3'd1 && avm_writedata == 32'h0003_0000)) begin
            failures++;
            $display("FAIL mid_raddr: got we=%b addr=%0d data=%h required 1/1/00030000",
                     avm_write, avm_address, avm_writedata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || avm_write !== 1'b0) begin
            failures++; $display("FAIL mid_reset: busy=%b we=%b required 0/0", busy, avm_write);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_no_done: done pulses=%0d busy=%b required 0/0",
                                 done_cnt - d0, busy);
        end
        exp_q.delete(); obs_q.delete();
        run_seq(32'h0005_0004, 1, 0, 0, 0, lat);
        tick();
        checks++;
        if (obs_q.size() != 6) begin
            failures++; $display("FAIL mid_rerun_count: got %0d required 6", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL mid_rerun_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int lat, d0;
        d0 = done_cnt;
        run_seq(32'h0006_0000, 0, 0, 0, 0, lat);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL b2b_done_cycle: busy=%b done=%b required 0/1", busy, done);
        end
        push_seq(32'h0007_0008);
        src_addr = 32'h0007_0008; start = 1'b1;
        tick(); start = 1'b0;
        checks++;
        if (!(busy && avm_write && avm_address == 3'd0 && avm_writedata == 32'h0)) begin
            failures++; $display("FAIL b2b_clr_stat: busy=%b we=%b addr=%0d required 1/1/0",
                                 busy, avm_write, avm_address);
        end
        run_seq(32'h0007_0008, 0, 0, 0, 1, lat);
        checks++;
        if (lat != 8) begin
            failures++; $display("FAIL b2b_latency: got %0d required 8", lat);
        end
        tick();
        checks++;
        if (done_cnt != d0 + 2) begin
            failures++; $display("FAIL b2b_done_pulses: got %0d required 2", done_cnt - d0);
        end
        checks++;
        if (obs_q.size() != 12) begin
            failures++; $display("FAIL b2b_count: got %0d required 12", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL b2b_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef VRAM_DMA_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, d0, t0;
        bit seen;
        d0 = done_cnt; t0 = to_cnt; seen = 0; cyc = 0;
        push_seq(32'h0009_0000);
        src_addr = 32'h0009_0000; start = 1'b1;
        for (int i = 0; i < (1 << 20) + 64; i++) begin
            tick(); cyc++; start = 1'b0;
            if (timeout_err) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || cyc != (1 << 20) + 7) begin
            failures++; $display("FAIL timeout_latency: got %0d required %0d", cyc, (1 << 20) + 7);
        end
        tick(); tick();
        checks++;
        if (to_cnt != t0 + 1 || done_cnt != d0) begin
            failures++; $display("FAIL timeout_pulses: to=%0d done=%0d required 1/0",
                                 to_cnt - t0, done_cnt - d0);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [34:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL timeout_write: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef VRAM_DMA_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (to_cnt != 0) begin
            failures++; $display("FAIL no_timeout_pulse: got %0d required 0", to_cnt);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
